// File: rtl/gshare_btb.sv
// Gshare branch predictor with a direct-mapped BTB and a small return-address stack.
// Lookups register on pred_oe; resolve-stage feedback trains the PHT, BTB and history.
module gshare_btb #(
    parameter int SCALE     = 10,
    parameter int GHR_WIDTH = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             pred_oe,
    input  logic [31:0]      pred_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [SCALE-1:0] pred_idx,
    input  logic             fb_we,
    input  logic [31:0]      fb_pc,
    input  logic [SCALE-1:0] fb_idx,
    input  logic             fb_taken,
    input  logic [31:0]      fb_target,
    input  logic [1:0]       fb_kind,
    input  logic             flush
);
    localparam int ENTRIES = 1 << SCALE;
    localparam int TAG_W   = 30 - SCALE;
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [1:0] K_BRANCH = 2'd0;
    localparam logic [1:0] K_CALL   = 2'd2;
    localparam logic [1:0] K_RET    = 2'd3;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_next;
    logic [SCALE-1:0] init_idx;

    logic [1:0]       pht [ENTRIES];
    logic [ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0] btb_tag [ENTRIES];
    logic [31:0]      btb_target [ENTRIES];
    logic [1:0]       btb_kind [ENTRIES];

    logic [GHR_WIDTH-1:0] ghr;
    logic [31:0]      ras [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr, ras_ptr_inc;
    logic [CNT_W-1:0] ras_cnt;

    // Init walk: one PHT entry per cycle, then the predictor goes live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) init_idx <= init_idx + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (&init_idx) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign ready = (state == RUN);

    logic             fb_ok, fb_branch, btb_we;
    logic [SCALE-1:0] fb_bidx;
    logic [1:0]       pht_cur, pht_next;

    assign fb_ok     = fb_we & ready;
    assign fb_branch = fb_ok & (fb_kind == K_BRANCH);
    assign btb_we    = fb_ok & fb_taken;
    assign fb_bidx   = fb_pc[2 +: SCALE];

    always_comb begin
        pht_cur  = pht[fb_idx];
        pht_next = pht_cur;
        if (fb_taken) begin
            if (pht_cur != 2'd3) pht_next = pht_cur + 2'd1;
        end else begin
            if (pht_cur != 2'd0) pht_next = pht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) pht[init_idx] <= 2'b01;
        else if (fb_branch) pht[fb_idx] <= pht_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (btb_we) begin
            btb_valid[fb_bidx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag[fb_bidx]    <= fb_pc[31:2+SCALE];
            btb_target[fb_bidx] <= fb_target;
            btb_kind[fb_bidx]   <= fb_kind;
        end
    end

    // History only advances on resolved conditional branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ghr <= '0;
        else if (fb_branch) ghr <= GHR_WIDTH'({ghr, fb_taken});
    end

    logic [SCALE-1:0] lk_bidx, lk_pidx;
    logic [1:0]       lk_kind;
    logic             lk_hit, lk_taken, ras_push, ras_pop;
    logic [31:0]      lk_target;

    // All reads see pre-edge contents, so a same-cycle update is read-first.
    always_comb begin
        lk_bidx  = pred_pc[2 +: SCALE];
        lk_pidx  = lk_bidx ^ SCALE'(ghr);
        lk_kind  = btb_kind[lk_bidx];
        lk_hit   = ready & btb_valid[lk_bidx] & (btb_tag[lk_bidx] == pred_pc[31:2+SCALE]);
        lk_taken = lk_hit & ((lk_kind != K_BRANCH) | pht[lk_pidx][1]);
        lk_target = (lk_kind == K_RET) ? ras[ras_ptr] : btb_target[lk_bidx];
        lk_target[0] = 1'b0;
    end

    assign ras_push    = pred_oe & lk_hit & (lk_kind == K_CALL);
    assign ras_pop     = pred_oe & lk_hit & (lk_kind == K_RET);
    assign ras_ptr_inc = ras_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_idx    <= '0;
        end else if (pred_oe) begin
            pred_hit    <= lk_hit;
            pred_taken  <= lk_taken;
            pred_target <= lk_target;
            pred_idx    <= lk_pidx;
        end
    end

    // ras_ptr names the top entry; popping the last entry leaves it as the stale top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (flush) begin
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr_inc;
            if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
        end else if (ras_pop) begin
            if (ras_cnt > CNT_W'(1)) ras_ptr <= ras_ptr - 1'b1;
            if (ras_cnt != '0) ras_cnt <= ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push && !flush) ras[ras_ptr_inc] <= pred_pc + 32'd4;
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[1:0], fb_pc[1:0]};

endmodule

// File: tb/tb_gshare_btb.sv
// Directed bench for gshare_btb (SCALE=4, GHR_WIDTH=4, RAS_DEPTH=2): expected lookups
// are queued by the driver and checked by an independent monitor.
module tb_gshare_btb;
  localparam int SCALE = 4;
  localparam logic [1:0] K_BRANCH = 2'd0, K_JUMP = 2'd1, K_CALL = 2'd2, K_RET = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic             pred_oe;
  logic [31:0]      pred_pc;
  logic             pred_hit, pred_taken;
  logic [31:0]      pred_target;
  logic [SCALE-1:0] pred_idx;
  logic             fb_we;
  logic [31:0]      fb_pc;
  logic [SCALE-1:0] fb_idx;
  logic             fb_taken;
  logic [31:0]      fb_target;
  logic [1:0]       fb_kind;
  logic             flush;

  gshare_btb #(.SCALE(4), .GHR_WIDTH(4), .RAS_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .pred_oe(pred_oe), .pred_pc(pred_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_idx(pred_idx),
    .fb_we(fb_we), .fb_pc(fb_pc), .fb_idx(fb_idx), .fb_taken(fb_taken),
    .fb_target(fb_target), .fb_kind(fb_kind), .flush(flush)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {check_target, hit, taken, target, idx}
  localparam int W = 1 + 1 + 1 + 32 + SCALE;
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // monitor: compares every registered lookup against the queue
  logic mon_oe;
  logic [W-1:0] mon_exp;
  always begin
    @(posedge clk);
    mon_oe = pred_oe;
    #1;
    if (mon_oe) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL lookup_unexpected: pc 0x%0h with empty expected queue", pred_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (pred_hit !== mon_exp[W-2] || pred_taken !== mon_exp[W-3] ||
            pred_idx !== mon_exp[SCALE-1:0] ||
            (mon_exp[W-1] && pred_target !== mon_exp[SCALE +: 32])) begin
          n_bad++;
          $display("FAIL lookup: got hit=%0b taken=%0b target=0x%0h idx=0x%0h, expected hit=%0b taken=%0b target=0x%0h idx=0x%0h",
                   pred_hit, pred_taken, pred_target, pred_idx,
                   mon_exp[W-2], mon_exp[W-3], mon_exp[SCALE +: 32], mon_exp[SCALE-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic lookup(input logic [31:0] pc, input logic chk, input logic h, input logic t,
                        input logic [31:0] tg, input logic [SCALE-1:0] ix);
    exp_q.push_back({chk, h, t, tg, ix});
    @(negedge clk);
    pred_oe = 1'b1;
    pred_pc = pc;
    @(posedge clk);
    #1 pred_oe = 1'b0;
  endtask

  task automatic set_fb(input logic [31:0] pc, input logic [SCALE-1:0] ix, input logic tk,
                        input logic [31:0] tg, input logic [1:0] kind);
    fb_we = 1'b1; fb_pc = pc; fb_idx = ix; fb_taken = tk; fb_target = tg; fb_kind = kind;
  endtask

  task automatic feedback(input logic [31:0] pc, input logic [SCALE-1:0] ix, input logic tk,
                          input logic [31:0] tg, input logic [1:0] kind);
    @(negedge clk);
    set_fb(pc, ix, tk, tg, kind);
    @(posedge clk);
    #1 fb_we = 1'b0;
  endtask

  task automatic lookup_with_fb(input logic [31:0] pc, input logic [31:0] tg_exp,
                                input logic [SCALE-1:0] ix_exp, input logic [31:0] fb_tg,
                                input logic [1:0] kind);
    exp_q.push_back({1'b1, 1'b1, 1'b1, tg_exp, ix_exp});
    @(negedge clk);
    pred_oe = 1'b1;
    pred_pc = pc;
    set_fb(pc, 4'd0, 1'b1, fb_tg, kind);
    @(posedge clk);
    #1 begin pred_oe = 1'b0; fb_we = 1'b0; end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  int start;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pred_oe = 1'b0; pred_pc = '0; fb_we = 1'b0; fb_pc = '0; fb_idx = '0;
    fb_taken = 1'b0; fb_target = '0; fb_kind = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_hit", pred_hit, 0);
    check("rst_taken", pred_taken, 0);
    check("rst_target", pred_target, 0);
    check("rst_idx", pred_idx, 0);

    // reset again part-way through the walk
    @(negedge clk) rst = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 check("midwalk_rst_ready", ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    start = cyc;
    // ignored: predictor still initialising
    feedback(32'h44, 4'd3, 1'b1, 32'h900, K_BRANCH);
    while (!ready && (cyc - start) < 100) begin
      @(posedge clk);
      #1;
    end
    check("walk_cycles", 64'(cyc - start), 16);
    check("ready_after_walk", ready, 1);

    lookup(32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 4'h1);

    // gshare training on 0x40 (BTB idx 0); ghr 0 -> 1 -> 3
    feedback(32'h40, 4'd3, 1'b1, 32'h100, K_BRANCH);
    feedback(32'h40, 4'd3, 1'b1, 32'h100, K_BRANCH);
    lookup(32'h40, 1'b1, 1'b1, 1'b1, 32'h100, 4'h3);
    feedback(32'h40, 4'd3, 1'b1, 32'h100, K_BRANCH);   // PHT[3] stays 3, ghr 7
    feedback(32'h40, 4'd3, 1'b0, 32'hBAD0, K_BRANCH);  // PHT[3] 2, ghr E
    feedback(32'h40, 4'd3, 1'b0, 32'hBAD0, K_BRANCH);  // PHT[3] 1, ghr C
    feedback(32'h40, 4'd9, 1'b1, 32'h100, K_BRANCH);   // ghr 9
    feedback(32'h40, 4'd9, 1'b1, 32'h100, K_BRANCH);   // ghr 3
    lookup(32'h40, 1'b1, 1'b1, 1'b0, 32'h100, 4'h3);

    // call/return pair; ghr stays 3
    feedback(32'h10, 4'd0, 1'b1, 32'h200, K_CALL);
    feedback(32'h204, 4'd0, 1'b1, 32'hDEAD0, K_RET);
    lookup(32'h10, 1'b1, 1'b1, 1'b1, 32'h200, 4'h7);
    lookup(32'h204, 1'b1, 1'b1, 1'b1, 32'h14, 4'h2);

    // three calls into a two-entry stack, then three returns
    feedback(32'h20, 4'd0, 1'b1, 32'h300, K_CALL);
    feedback(32'h30, 4'd0, 1'b1, 32'h380, K_CALL);
    lookup(32'h10, 1'b1, 1'b1, 1'b1, 32'h200, 4'h7);
    lookup(32'h20, 1'b1, 1'b1, 1'b1, 32'h300, 4'hB);
    lookup(32'h30, 1'b1, 1'b1, 1'b1, 32'h380, 4'hF);
    lookup(32'h204, 1'b1, 1'b1, 1'b1, 32'h34, 4'h2);
    lookup(32'h204, 1'b1, 1'b1, 1'b1, 32'h24, 4'h2);
    lookup(32'h204, 1'b1, 1'b1, 1'b1, 32'h24, 4'h2);

    // flush empties the stack: both returns see the same stale top
    lookup(32'h10, 1'b1, 1'b1, 1'b1, 32'h200, 4'h7);
    lookup(32'h20, 1'b1, 1'b1, 1'b1, 32'h300, 4'hB);
    do_flush();
    lookup(32'h204, 1'b1, 1'b1, 1'b1, 32'h24, 4'h2);
    lookup(32'h204, 1'b1, 1'b1, 1'b1, 32'h24, 4'h2);

    // same-cycle lookup and update is read-first
    feedback(32'h3C, 4'd0, 1'b1, 32'h400, K_JUMP);
    lookup_with_fb(32'h3C, 32'h400, 4'hC, 32'h501, K_JUMP);
    lookup(32'h3C, 1'b1, 1'b1, 1'b1, 32'h500, 4'hC);

    // outputs hold while pred_oe is low
    repeat (3) @(posedge clk);
    #1;
    check("hold_target", pred_target, 32'h500);
    check("hold_hit", pred_hit, 1);
    check("hold_idx", pred_idx, 4'hC);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gshare_btb.md
GSHARE_BTB -- requirements
Module: gshare_btb

Interface
REQ-001 SHALL have parameter SCALE, default 10, meaning index bits (2^SCALE PHT and BTB entries).
REQ-002 SHALL have parameter GHR_WIDTH, default 8, meaning global history length, 1..SCALE.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries, power of 2, at least 2.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ready  out  1  high when the PHT init walk is done.
REQ-007 SHALL have port pred_oe  in  1  lookup strobe; outputs hold when low.
REQ-008 SHALL have port pred_pc  in  32  fetch PC.
REQ-009 SHALL have port pred_hit  out  1  BTB tag match.
REQ-010 SHALL have port pred_taken  out  1  predicted control transfer.
REQ-011 SHALL have port pred_target  out  32  predicted target.
REQ-012 SHALL have port pred_idx  out  SCALE  PHT index used; carried down the pipe as meta.
REQ-013 SHALL have port fb_we  in  1  resolve-stage update strobe.
REQ-014 SHALL have port fb_pc  in  32  resolved PC.
REQ-015 SHALL have port fb_idx  in  SCALE  pred_idx returned with the instruction.
REQ-016 SHALL have port fb_taken  in  1  actual outcome.
REQ-017 SHALL have port fb_target  in  32  actual target.
REQ-018 SHALL have port fb_kind  in  2  0=BRANCH, 1=JUMP, 2=CALL, 3=RET.
REQ-019 SHALL have port flush  in  1  mispredict recovery; empties the RAS.

Function
REQ-020 Lookup latency SHALL be 1 cycle: pred_* are registered on the clk edge where pred_oe=1 and held while pred_oe=0.
REQ-021 Index SHALL be computed as: PHT index = pred_pc[2+:SCALE] XOR ghr zero-extended to SCALE bits; BTB index = pred_pc[2+:SCALE]; tag = pred_pc[31:2+SCALE].
REQ-022 pred_hit SHALL equal valid AND tag match; when ready=0, pred_hit and pred_taken SHALL be 0.
REQ-023 pred_taken SHALL equal hit AND (kind!=BRANCH OR counter[1]).
REQ-024 pred_target SHALL be the RAS top for kind RET, otherwise the BTB target; bit 0 SHALL be forced to 0.
REQ-025 RAS push: a lookup hit of kind CALL SHALL push pred_pc+4.
REQ-026 RAS pop: a lookup hit of kind RET SHALL pop.
REQ-027 RAS overflow SHALL wrap and overwrite the oldest entry; count saturates at RAS_DEPTH.
REQ-028 RAS pop when empty SHALL return the stale top entry and keep count 0.
REQ-029 flush SHALL set the RAS count to 0; flush has priority over a push or pop in the same cycle.
REQ-030 On fb_we with fb_kind=BRANCH, PHT[fb_idx] SHALL update as a 2-bit saturating counter: +1 if taken, -1 if not, no change at 3 (up) or 0 (down).
REQ-031 On fb_we with fb_kind=BRANCH, ghr SHALL shift as ghr <= {ghr[GHR_WIDTH-2:0], fb_taken}; history is non-speculative.
REQ-032 On fb_we with fb_taken=1, BTB[fb_pc index] SHALL be written with valid=1, tag, fb_target, fb_kind.
REQ-033 On fb_we with fb_kind=BRANCH and fb_taken=0, the BTB SHALL be left unchanged.
REQ-034 A lookup and an update to the same entry in the same cycle SHALL be read-first: the lookup sees the old contents.
REQ-035 fb_we while ready=0 SHALL be ignored.

Reset
REQ-036 rst SHALL asynchronously clear ghr, all BTB valid bits, RAS count and pointer, ready, pred_hit, pred_taken, pred_target=0 and pred_idx=0.
REQ-037 Init FSM state INIT SHALL be entered on reset and write PHT[i]=2'b01 for i=0..2^SCALE-1, one entry per cycle.
REQ-038 The FSM SHALL then go to RUN and set ready=1, after exactly 2^SCALE cycles following reset deassertion.
REQ-039 rst asserted mid-walk SHALL restart the walk from index 0.

Verification (SCALE=4, GHR_WIDTH=4, RAS_DEPTH=2)
REQ-040 Release rst -> ready=0 for 16 cycles, then 1; every PHT entry reads 2'b01.
REQ-041 Feedback BRANCH pc=0x40, taken twice, target 0x100; then lookup 0x40 with ghr=4'b0011 -> pred_idx=0x0^0x3=0x3 at the second update's index path, pred_hit=1, pred_target=0x100; the counter saturates at 3 after a third taken update.
REQ-042 Write CALL at 0x10 (target 0x200) and RET at 0x204; lookup 0x10 then 0x204 -> second lookup gives pred_target=0x14.
REQ-043 Three CALL hits then three RET hits -> targets newest, middle, then the stale middle again; count never exceeds 2.
REQ-044 Lookup and update of the same entry in the same cycle -> old target is returned, new target on the next lookup.
REQ-045 Assert rst at walk cycle 7 -> ready stays 0 for a further 16 cycles after release.
